// File: rtl/shift8_sequencer.sv
// shift8_sequencer: multi-cycle single-bit shifter with start/abort handshake and registered result
module shift8_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d_in,
    input  logic             abort,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] work, work_n, q_n, shifted;
    logic [AMT_W-1:0] count, count_n;
    logic [1:0] op_r, op_n;
    assign ready = state == IDLE;
    assign busy  = state != IDLE;
    assign done  = state == DONE;
    assign shifted = op_r == 2'b00 ? {work[WIDTH-2:0], 1'b0} :
                     op_r == 2'b01 ? {1'b0, work[WIDTH-1:1]} :
                     op_r == 2'b10 ? {work[WIDTH-1], work[WIDTH-1:1]} :
                                     {work[0], work[WIDTH-1:1]};
    always_comb begin
        state_n = state;
        work_n  = work;
        op_n    = op_r;
        count_n = count;
        q_n     = q;
        case (state)
            IDLE: if (start) begin
                work_n  = d_in;
                op_n    = op;
                count_n = amt;
                state_n = amt == '0 ? DONE : SHIFT;
                q_n     = amt == '0 ? d_in : q;
            end
            SHIFT: if (abort) begin
                state_n = IDLE;
            end else begin
                work_n  = shifted;
                count_n = count - AMT_W'(1);
                state_n = count == AMT_W'(1) ? DONE : SHIFT;
                q_n     = count == AMT_W'(1) ? shifted : q;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            op_r  <= '0;
            count <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            work  <= work_n;
            op_r  <= op_n;
            count <= count_n;
            q     <= q_n;
        end
    end
endmodule

// File: tb/tb_shift8_sequencer.sv
// tb_shift8_sequencer: directed literal checks plus randomized traffic against a cycle-count model
module tb_shift8_sequencer;
    logic clk = 0, reset = 1, start = 0, abort = 0;
    logic [1:0] op = 0;
    logic [2:0] amt = 0;
    logic [7:0] d_in = 0;
    logic ready, busy, done;
    logic [7:0] q;
    int n_chk = 0, n_fail = 0;
    bit chk_en = 0;
    bit m_busy = 0, m_done = 0;
    int m_left = 0;
    logic [7:0] m_q = 0, m_res = 0;

    shift8_sequencer dut (.clk(clk), .reset(reset), .start(start), .op(op), .amt(amt),
        .d_in(d_in), .abort(abort), .ready(ready), .busy(busy), .done(done), .q(q));

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(logic [1:0] o, int a, logic [7:0] d);
        logic [15:0] dd = {d, d};
        case (o)
            2'd0: return d << a;
            2'd1: return d >> a;
            2'd2: return 8'($signed(d) >>> a);
            default: return 8'(dd >> a);
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted command is busy for amt shift edges, then one done cycle.
    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_left = 0; m_q = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            if (abort) m_busy = 0;
            else begin
                m_left--;
                if (m_left == 0) begin m_done = 1; m_q = m_res; end
            end
        end else if (start) begin
            m_res = ref_shift(op, int'(amt), d_in);
            m_busy = 1;
            m_left = int'(amt);
            if (amt == 0) begin m_done = 1; m_q = m_res; end
        end
    end

    always @(negedge clk) if (chk_en) begin
        check("model_ready", ready, !m_busy);
        check("model_busy", busy, m_busy);
        check("model_done", done, m_done);
        check("model_q", q, m_q);
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(logic [1:0] o, logic [2:0] a, logic [7:0] d, logic [7:0] exp_q, int poke);
        int lat = 0, w = 0;
        while (!ready && w < 20) begin step(); w++; end
        if (!ready) begin n_chk++; n_fail++; $display("FAIL wait_ready: timeout"); end
        start = 1; op = o; amt = a; d_in = d;
        step();
        start = 0;
        lat = 1;
        while (!done && lat < 20) begin
            if (poke && lat == 2) begin start = 1; op = 2'd0; amt = 3'd1; d_in = 8'h0F; end
            step();
            start = 0;
            lat++;
        end
        check("latency", lat, int'(a) + 1);
        check("result_q", q, exp_q);
        check("done_busy", busy, 1);
    endtask

    initial begin
        start = 1;
        step(); step();
        chk_en = 1;
        check("rst_q", q, 8'h00);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 0; start = 0;
        issue(2'd0, 3'd1, 8'h55, 8'hAA, 0);
        step();
        check("ready_after", ready, 1);
        issue(2'd2, 3'd3, 8'hEB, 8'hFD, 1);
        issue(2'd3, 3'd7, 8'h7F, 8'hFE, 0);
        issue(2'd1, 3'd0, 8'h55, 8'h55, 0);
        step();
        start = 1; op = 2'd0; amt = 3'd5; d_in = 8'h01;
        step(); start = 0;
        step(); step();
        abort = 1;
        step(); abort = 0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_q", q, 8'h55);
        start = 1; op = 2'd1; amt = 3'd6; d_in = 8'hC3;
        step(); start = 0;
        step(); step();
        reset = 1;
        step(); reset = 0;
        check("rreset_q", q, 8'h00);
        check("rreset_ready", ready, 1);
        for (int i = 0; i < 10; i++) begin
            check("rreset_nodone", done, 0);
            step();
        end
        for (int i = 0; i < 2000; i++) begin
            start = ($urandom_range(0, 1) == 1);
            abort = ($urandom_range(0, 7) == 0);
            reset = ($urandom_range(0, 49) == 0);
            op = 2'($urandom_range(0, 3));
            amt = 3'($urandom_range(0, 7));
            d_in = 8'($urandom_range(0, 255));
            step();
        end
        start = 0; abort = 0; reset = 0;
        step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
